// File: rtl/alarm_ctrl.sv
// alarm_ctrl: sequences the alarm tone generator enable. It compares the running clock
// against the programmed alarm time, rings, and handles stop, limited snooze and the
// auto-timeout of an unanswered alarm.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,   // seconds of ringing before auto-stop (>= 1)
    parameter int SNOOZE_SEC = 300,  // seconds of silence per snooze (>= 1)
    parameter int MAX_SNOOZE = 3     // snoozes per alarm event, 0 disables snooze
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       alarm_sound,
    output logic       snoozing,
    output logic [1:0] snooze_left,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RINGING = 3'd2,
        SNOOZE  = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int RING_W = $clog2(RING_SEC) + 1;
    localparam int SNZ_W  = $clog2(SNOOZE_SEC) + 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    state_e            state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [1:0]        snooze_left_q, snooze_left_d;
    logic              alarm_sound_q, snoozing_q;
    logic              match, hit;

    // The alarm minute is "current"; a hit is the tick that starts that minute.
    assign match = (cur_hour == alarm_hour) && (cur_min == alarm_min);
    assign hit   = tick_1hz && match && (cur_sec == 6'd0);

    // Next-state and counter logic; alarm_en, stop, timeout, snooze, tick in priority order.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        snooze_left_d = snooze_left_q;

        if (!alarm_en) begin
            state_d       = IDLE;
            ring_cnt_d    = '0;
            snz_cnt_d     = '0;
            snooze_left_d = SNZ_MAX;
        end else begin
            case (state_q)
                IDLE: begin
                    // Enabling inside the alarm minute must not ring this time round.
                    state_d = match ? DONE : ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        state_d       = RINGING;
                        ring_cnt_d    = '0;
                        snooze_left_d = SNZ_MAX;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_d = DONE;
                    end else if (tick_1hz && (ring_cnt_q == RING_LAST)) begin
                        state_d = DONE;
                    end else if (snooze_btn && (snooze_left_q != 2'd0)) begin
                        state_d       = SNOOZE;
                        snz_cnt_d     = '0;
                        snooze_left_d = snooze_left_q - 2'd1;
                    end else if (tick_1hz) begin
                        ring_cnt_d = ring_cnt_q + RING_W'(1);
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = DONE;
                    end else if (tick_1hz && (snz_cnt_q == SNZ_LAST)) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end else if (tick_1hz) begin
                        snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                    end
                end
                DONE: begin
                    // Hold until the alarm minute is over so it cannot re-trigger.
                    if (!match) state_d = ARMED;
                end
                default: begin
                    state_d       = IDLE;
                    ring_cnt_d    = '0;
                    snz_cnt_d     = '0;
                    snooze_left_d = SNZ_MAX;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset silences the tone immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snooze_left_q <= SNZ_MAX;
            alarm_sound_q <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_left_q <= snooze_left_d;
            // Decoded from the next state so the flops track the state with no extra delay.
            alarm_sound_q <= (state_d == RINGING);
            snoozing_q    <= (state_d == SNOOZE);
        end
    end

    assign alarm_sound = alarm_sound_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenarios plus randomized stimulus, checked every cycle
// against a countdown-based behavioural model of the alarm sequencer.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int DAY        = 86400;

    localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNOOZE = 3, S_DONE = 4;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic       stop_btn;
    logic       snooze_btn;
    logic       alarm_sound;
    logic       snoozing;
    logic [1:0] snooze_left;
    logic [2:0] state_o;

    int t;          // seconds of day shown on cur_*
    int n_total;
    int n_bad;

    // Behavioural model: time-remaining countdowns and a used-snooze tally.
    int m_state;
    int m_ring_left;
    int m_snz_left;
    int m_used;

    assign cur_hour = 5'(t / 3600);
    assign cur_min  = 6'((t / 60) % 60);
    assign cur_sec  = 6'(t % 60);

    alarm_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_en   (alarm_en),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .alarm_sound(alarm_sound),
        .snoozing   (snoozing),
        .snooze_left(snooze_left),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_alarm_minute();
        return (t / 3600 == int'(alarm_hour)) && ((t / 60) % 60 == int'(alarm_min));
    endfunction

    task automatic model_reset();
        m_state     = S_IDLE;
        m_ring_left = 0;
        m_snz_left  = 0;
        m_used      = 0;
    endtask

    // One clock of the model, applied with the inputs present at the edge.
    task automatic model_step(input bit tk, input bit stp, input bit snz);
        bit in_min;
        in_min = in_alarm_minute();
        if (!alarm_en) begin
            m_state = S_IDLE;
            m_used  = 0;
        end else begin
            case (m_state)
                S_IDLE:  m_state = in_min ? S_DONE : S_ARMED;
                S_ARMED: if (tk && in_min && (t % 60 == 0)) begin
                    m_state     = S_RING;
                    m_ring_left = RING_SEC;
                    m_used      = 0;
                end
                S_RING: begin
                    if (stp) m_state = S_DONE;
                    else if (tk && m_ring_left == 1) m_state = S_DONE;
                    else if (snz && m_used < MAX_SNOOZE) begin
                        m_state    = S_SNOOZE;
                        m_snz_left = SNOOZE_SEC;
                        m_used++;
                    end else if (tk) m_ring_left--;
                end
                S_SNOOZE: begin
                    if (stp) m_state = S_DONE;
                    else if (tk) begin
                        m_snz_left--;
                        if (m_snz_left == 0) begin
                            m_state     = S_RING;
                            m_ring_left = RING_SEC;
                        end
                    end
                end
                default: if (!in_min) m_state = S_ARMED;
            endcase
        end
    endtask

    task automatic compare_all();
        check("state", int'(state_o), m_state);
        check("sound", int'(alarm_sound), int'(m_state == S_RING));
        check("snoozing", int'(snoozing), int'(m_state == S_SNOOZE));
        check("snooze_left", int'(snooze_left), MAX_SNOOZE - m_used);
    endtask

    // One clock: present inputs, clock the DUT and the model, then compare #1 later.
    task automatic step(input bit tk, input bit stp, input bit snz);
        tick_1hz   = tk;
        stop_btn   = stp;
        snooze_btn = snz;
        if (tk) t = (t + 1) % DAY;
        @(posedge clk);
        model_step(tk, stp, snz);
        #1;
        tick_1hz   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        compare_all();
    endtask

    // One second: a tick followed by two quiet clocks.
    task automatic sec();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        tick_1hz   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        alarm_en   = 1'b0;
        alarm_hour = 5'd7;
        alarm_min  = 6'd30;
        t          = hms(7, 29, 57);
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(state_o), S_IDLE);
        check("rst_sound", int'(alarm_sound), 0);
        check("rst_snoozing", int'(snoozing), 0);
        check("rst_left", int'(snooze_left), MAX_SNOOZE);
        reset = 1'b0;

        // T1: ring one clock after the 07:30:00 tick.
        alarm_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("t1_armed", int'(state_o), S_ARMED);
        sec();
        sec();
        check("t1_quiet_0759", int'(alarm_sound), 0);
        step(1'b1, 1'b0, 1'b0);
        check("t1_ring", int'(alarm_sound), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // T2: stop and snooze together -> stop wins; DONE holds through the minute.
        sec();
        sec();
        step(1'b0, 1'b1, 1'b1);
        check("t2_done", int'(state_o), S_DONE);
        check("t2_sound", int'(alarm_sound), 0);
        check("t2_left", int'(snooze_left), MAX_SNOOZE);
        repeat (57) sec();
        check("t2_hold_0759", int'(state_o), S_DONE);
        step(1'b1, 1'b0, 1'b0);
        check("t2_rearm", int'(state_o), S_ARMED);

        // T3: three snoozes of five seconds, fourth ignored, then timeout.
        t = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t3_ring", int'(alarm_sound), 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("t3_left", int'(snooze_left), 2 - k);
            check("t3_snoozing", int'(snoozing), 1);
            repeat (4) sec();
            check("t3_silent", int'(alarm_sound), 0);
            sec();
            check("t3_rering", int'(alarm_sound), 1);
        end
        step(1'b0, 1'b0, 1'b1);
        check("t3_4th_ignored", int'(state_o), S_RING);
        check("t3_left_zero", int'(snooze_left), 0);
        repeat (59) sec();
        check("t3_still_ring", int'(alarm_sound), 1);
        step(1'b1, 1'b0, 1'b0);
        check("t3_timeout", int'(state_o), S_DONE);
        step(1'b0, 1'b0, 1'b0);

        // T4: enabling inside the alarm minute goes straight to DONE; next day rings.
        alarm_en = 1'b0;
        t        = hms(7, 30, 20);
        step(1'b0, 1'b0, 1'b0);
        check("t4_idle", int'(state_o), S_IDLE);
        alarm_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("t4_done", int'(state_o), S_DONE);
        repeat (3) sec();
        check("t4_no_ring", int'(alarm_sound), 0);
        t = hms(7, 30, 58);
        step(1'b0, 1'b0, 1'b0);
        sec();
        step(1'b1, 1'b0, 1'b0);
        check("t4_armed", int'(state_o), S_ARMED);
        t = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t4_next_day_ring", int'(alarm_sound), 1);

        // T5: dropping alarm_en during SNOOZE returns to IDLE with a fresh snooze budget.
        step(1'b0, 1'b0, 1'b1);
        check("t5_snooze", int'(snoozing), 1);
        sec();
        sec();
        alarm_en = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("t5_idle", int'(state_o), S_IDLE);
        check("t5_left", int'(snooze_left), MAX_SNOOZE);
        check("t5_not_snoozing", int'(snoozing), 0);
        repeat (5) sec();
        check("t5_no_ring", int'(alarm_sound), 0);
        alarm_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("t5_reenable_done", int'(state_o), S_DONE);

        // T6: asynchronous reset while ringing silences before the next edge.
        t = hms(7, 29, 0);
        step(1'b0, 1'b0, 1'b0);
        t = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t6_ring", int'(alarm_sound), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_sound", int'(alarm_sound), 0);
        check("t6_async_state", int'(state_o), S_IDLE);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
        step(1'b0, 1'b0, 1'b0);
        check("t6_after_reset", int'(state_o), S_DONE);

        // Randomized phase: buttons, enables, alarm-time changes and time jumps.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                alarm_en = ~alarm_en;
            end else if (r < 9) begin
                alarm_hour = 5'($urandom_range(0, 23));
                alarm_min  = 6'($urandom_range(0, 59));
            end else if (r < 18) begin
                t = (hms(int'(alarm_hour), int'(alarm_min), 0) - int'($urandom_range(1, 4)) + DAY) % DAY;
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 14) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
